// File: rtl/board_io_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : board_io_seq                                                  |
// | Brief    : Front-panel controller. Debounces three push-buttons, loads   |
// |            switch words into NLOAD slots in sequence, emits one-cycle    |
// |            manual-clock pulses, and steps the display through BLANK,     |
// |            NCH data channels and a lamp-test state. Fully clk-synchronous|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module board_io_seq #(
    parameter int W       = 32,
    parameter int NLOAD   = 3,
    parameter int NCH     = 4,
    parameter int DEB_CYC = 20,
    parameter int LIVE    = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [W-1:0]                                  sw,
    input  logic                                          load_en,
    input  logic                                          btn_load,
    input  logic                                          btn_step,
    input  logic                                          btn_clk,
    input  logic [NCH*W-1:0]                              ch_data,
    output logic [NLOAD*W-1:0]                            load_word,
    output logic [NLOAD-1:0]                              load_valid,
    output logic [((NLOAD > 1) ? $clog2(NLOAD) : 1)-1:0]  load_idx,
    output logic                                          load_stb,
    output logic                                          man_clk,
    output logic [$clog2(NCH+2)-1:0]                      disp_sel,
    output logic [W-1:0]                                  disp_data,
    output logic                                          disp_all8
);

    localparam int c_idx_w = (NLOAD > 1) ? $clog2(NLOAD) : 1;
    localparam int c_sel_w = $clog2(NCH + 2);
    localparam int c_cnt_w = $clog2(DEB_CYC + 1);
    localparam int c_nbtn  = 3;

    // Button positions inside the packed button vectors
    localparam int c_b_load = 0;
    localparam int c_b_step = 1;
    localparam int c_b_clk  = 2;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYC - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NLOAD - 1);

    // Display state encoding: 0 blank, 1..NCH channel, NCH+1 lamp test
    localparam logic [c_sel_w-1:0] c_st_blank = '0;
    localparam logic [c_sel_w-1:0] c_st_lamp  = c_sel_w'(NCH + 1);

    logic [c_nbtn-1:0]  w_btn_raw;
    logic [c_nbtn-1:0]  r_sync1;
    logic [c_nbtn-1:0]  r_sync2;
    logic [c_nbtn-1:0]  w_deb;
    logic [c_nbtn-1:0]  r_deb_d;
    logic [c_nbtn-1:0]  w_press;

    logic [NLOAD*W-1:0] r_load_word;
    logic [NLOAD-1:0]   r_load_valid;
    logic [c_idx_w-1:0] r_load_idx;
    logic               r_load_stb;
    logic               r_man_clk;

    logic [c_sel_w-1:0] r_disp_sel;
    logic [c_sel_w-1:0] w_sel_next;
    logic [c_sel_w-1:0] w_mux_sel;
    logic [W-1:0]       w_mux_word;
    logic               w_mux_is_ch;
    logic               w_data_upd;
    logic [W-1:0]       r_disp_data;
    logic               r_disp_all8;

    assign w_btn_raw = {btn_clk, btn_step, btn_load};

    // Two-flop synchroniser on the raw buttons plus the delayed debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
        end
    end

    generate
        for (genvar gi = 0; gi < c_nbtn; gi++) begin : g_btn
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_deb;

            // Accept a level change only after DEB_CYC consecutive mismatches
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2[gi] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                    r_deb <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // Rising edge of the debounced level only; releases are silent
    assign w_press = w_deb & ~r_deb_d;

    // Slot loader: capture into the current slot, then advance with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_word  <= '0;
            r_load_valid <= '0;
            r_load_idx   <= '0;
            r_load_stb   <= 1'b0;
        end else begin
            r_load_stb <= 1'b0;
            if (w_press[c_b_load] && load_en) begin
                for (int k = 0; k < NLOAD; k++) begin
                    if (r_load_idx == c_idx_w'(k)) begin
                        r_load_word[k*W +: W] <= sw;
                        r_load_valid[k]       <= 1'b1;
                    end
                end
                r_load_stb <= 1'b1;
                r_load_idx <= (r_load_idx == c_idx_last) ? '0 : r_load_idx + c_idx_w'(1);
            end
        end
    end

    // Manual clock is the registered clock-button press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_man_clk <= 1'b0;
        end else begin
            r_man_clk <= w_press[c_b_clk];
        end
    end

    assign w_sel_next = (r_disp_sel == c_st_lamp) ? c_st_blank : r_disp_sel + c_sel_w'(1);

    // Snapshot mode looks at the state being entered; live mode at the current one
    assign w_mux_sel  = (LIVE != 0) ? r_disp_sel : w_sel_next;
    assign w_data_upd = (LIVE != 0) ? 1'b1 : w_press[c_b_step];

    // Channel word selected by w_mux_sel, with a flag for the channel states
    always_comb begin
        w_mux_word  = '0;
        w_mux_is_ch = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_mux_sel == c_sel_w'(k + 1)) begin
                w_mux_word  = ch_data[k*W +: W];
                w_mux_is_ch = 1'b1;
            end
        end
    end

    // Display state machine: one step per press, lamp wraps to blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_sel  <= c_st_blank;
            r_disp_all8 <= 1'b0;
        end else if (w_press[c_b_step]) begin
            r_disp_sel  <= w_sel_next;
            r_disp_all8 <= (w_sel_next == c_st_lamp);
        end
    end

    // Display word: blank clears, channels load, lamp test holds the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_data <= '0;
        end else if (w_data_upd) begin
            if (w_mux_sel == c_st_blank) begin
                r_disp_data <= '0;
            end else if (w_mux_is_ch) begin
                r_disp_data <= w_mux_word;
            end
        end
    end

    assign load_word  = r_load_word;
    assign load_valid = r_load_valid;
    assign load_idx   = r_load_idx;
    assign load_stb   = r_load_stb;
    assign man_clk    = r_man_clk;
    assign disp_sel   = r_disp_sel;
    assign disp_data  = r_disp_data;
    assign disp_all8  = r_disp_all8;

endmodule
`default_nettype wire

// File: tb/tb_board_io_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_board_io_seq                                               |
// | Brief    : Scoreboard bench for board_io_seq (snapshot and live display  |
// |            instances driven from the same panel stimulus).               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_board_io_seq;

    localparam int W       = 32;
    localparam int NLOAD   = 3;
    localparam int NCH     = 4;
    localparam int DEB_CYC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       sw;
    logic               load_en, btn_load, btn_step, btn_clk;
    logic [NCH*W-1:0]   ch_data;

    logic [NLOAD*W-1:0] load_word,  l_load_word;
    logic [NLOAD-1:0]   load_valid, l_load_valid;
    logic [1:0]         load_idx,   l_load_idx;
    logic               load_stb,   l_load_stb;
    logic               man_clk,    l_man_clk;
    logic [2:0]         disp_sel,   l_disp_sel;
    logic [W-1:0]       disp_data,  l_disp_data;
    logic               disp_all8,  l_disp_all8;

    always #5 clk = ~clk;

    board_io_seq #(.W(W), .NLOAD(NLOAD), .NCH(NCH), .DEB_CYC(DEB_CYC), .LIVE(0)) dut (
        .clk(clk), .rst(rst), .sw(sw), .load_en(load_en),
        .btn_load(btn_load), .btn_step(btn_step), .btn_clk(btn_clk), .ch_data(ch_data),
        .load_word(load_word), .load_valid(load_valid), .load_idx(load_idx),
        .load_stb(load_stb), .man_clk(man_clk), .disp_sel(disp_sel),
        .disp_data(disp_data), .disp_all8(disp_all8)
    );

    board_io_seq #(.W(W), .NLOAD(NLOAD), .NCH(NCH), .DEB_CYC(DEB_CYC), .LIVE(1)) dut_live (
        .clk(clk), .rst(rst), .sw(sw), .load_en(load_en),
        .btn_load(btn_load), .btn_step(btn_step), .btn_clk(btn_clk), .ch_data(ch_data),
        .load_word(l_load_word), .load_valid(l_load_valid), .load_idx(l_load_idx),
        .load_stb(l_load_stb), .man_clk(l_man_clk), .disp_sel(l_disp_sel),
        .disp_data(l_disp_data), .disp_all8(l_disp_all8)
    );

    typedef struct {
        int                 cyc;
        logic [NLOAD*W-1:0] words;
        logic [NLOAD-1:0]   valid;
        int                 idx;
    } load_exp_t;

    typedef struct {
        int           cyc;
        int           sel;
        logic [W-1:0] data;
    } disp_exp_t;

    load_exp_t lq[$];
    disp_exp_t dq[$];
    int        mq[$];

    // Issue-side model: panel state once every issued press has taken effect
    logic [W-1:0]     mw [NLOAD];
    logic [NLOAD-1:0] mv;
    int               mi;
    int               ms;
    logic [W-1:0]     md;

    // Monitor-side model: what the outputs should show right now
    int               m_sel;
    logic [W-1:0]     m_data;
    logic [W-1:0]     m_live;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    load_exp_t le;
    disp_exp_t de;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_models();
        lq.delete();
        dq.delete();
        mq.delete();
        for (int k = 0; k < NLOAD; k++) mw[k] = '0;
        mv     = '0;
        mi     = 0;
        ms     = 0;
        md     = '0;
        m_sel  = 0;
        m_data = '0;
        m_live = '0;
    endtask

    task automatic expect_load(input int ec, input logic [W-1:0] v);
        load_exp_t e;
        mw[mi] = v;
        mv[mi] = 1'b1;
        mi     = (mi + 1) % NLOAD;
        e.cyc  = ec;
        for (int k = 0; k < NLOAD; k++) e.words[k*W +: W] = mw[k];
        e.valid = mv;
        e.idx   = mi;
        lq.push_back(e);
    endtask

    task automatic expect_step(input int ec);
        disp_exp_t e;
        ms = (ms + 1) % (NCH + 2);
        if (ms == 0)        md = '0;
        else if (ms <= NCH) md = ch_data[(ms-1)*W +: W];
        e.cyc  = ec;
        e.sel  = ms;
        e.data = md;
        dq.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_load_word"},  load_word,  '0);
        chk({tag, "_load_valid"}, load_valid, '0);
        chk({tag, "_load_idx"},   load_idx,   '0);
        chk({tag, "_load_stb"},   load_stb,   '0);
        chk({tag, "_man_clk"},    man_clk,    '0);
        chk({tag, "_disp_sel"},   disp_sel,   '0);
        chk({tag, "_disp_data"},  disp_data,  '0);
        chk({tag, "_disp_all8"},  disp_all8,  '0);
        chk({tag, "_live_data"},  l_disp_data, '0);
    endtask

    // One press of the buttons in b, held for hold samples, then released
    task automatic press(input logic [2:0] b, input int hold, input logic en, input logic [W-1:0] v);
        int ec;
        @(negedge clk);
        sw       = v;
        load_en  = en;
        btn_load = b[0];
        btn_step = b[1];
        btn_clk  = b[2];
        ec = cyc + DEB_CYC + 3;
        if (b[0] && en) expect_load(ec, v);
        if (b[1])       expect_step(ec);
        if (b[2])       mq.push_back(ec);
        repeat (hold) @(negedge clk);
        btn_load = 1'b0;
        btn_step = 1'b0;
        btn_clk  = 1'b0;
        repeat (DEB_CYC + 8) @(negedge clk);
    endtask

    // Scoreboard monitor: pops expectations on their due cycle, else expects idle
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            if (lq.size() > 0 && lq[0].cyc == cyc) begin
                le = lq.pop_front();
                chk("load_stb",   load_stb,   1'b1);
                chk("load_word",  load_word,  le.words);
                chk("load_valid", load_valid, le.valid);
                chk("load_idx",   load_idx,   le.idx);
            end else begin
                chk("load_stb_idle", load_stb, 1'b0);
            end

            if (mq.size() > 0 && mq[0] == cyc) begin
                void'(mq.pop_front());
                chk("man_clk", man_clk, 1'b1);
            end else begin
                chk("man_clk_idle", man_clk, 1'b0);
            end

            // Live display registers the state that was current before this edge
            if (m_sel == 0)        m_live = '0;
            else if (m_sel <= NCH) m_live = ch_data[(m_sel-1)*W +: W];
            chk("live_data", l_disp_data, m_live);

            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                de     = dq.pop_front();
                m_sel  = de.sel;
                m_data = de.data;
            end
            chk("disp_sel",  disp_sel,  m_sel);
            chk("disp_data", disp_data, m_data);
            chk("disp_all8", disp_all8, (m_sel == NCH + 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  b;
        int          hold, ec, c;
        logic        en;

        rst      = 1'b1;
        sw       = '0;
        load_en  = 1'b0;
        btn_load = 1'b0;
        btn_step = 1'b0;
        btn_clk  = 1'b0;
        ch_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        reset_models();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Slot loading with wrap, then an ignored press
        press(3'b001, 10, 1'b1, 32'h12345678);
        chk("first_idx",   load_idx,   2'd1);
        chk("first_valid", load_valid, 3'b001);
        chk("first_slot0", load_word[31:0], 32'h12345678);
        press(3'b001, 8, 1'b1, 32'hAAAA0001);
        press(3'b001, 8, 1'b1, 32'hBBBB0002);
        press(3'b001, 8, 1'b1, 32'hCCCC0003);
        chk("wrap_slot0", load_word[31:0],  32'hCCCC0003);
        chk("wrap_slot1", load_word[63:32], 32'hAAAA0001);
        chk("wrap_slot2", load_word[95:64], 32'hBBBB0002);
        chk("wrap_idx",   load_idx,   2'd1);
        chk("wrap_valid", load_valid, 3'b111);
        press(3'b001, 8, 1'b0, 32'hDEADBEEF);
        chk("dis_slot1", load_word[63:32], 32'hAAAA0001);
        chk("dis_idx",   load_idx,   2'd1);

        // Bounced step press: high 2, low 1, high 6
        @(negedge clk); btn_step = 1'b1;
        repeat (2) @(negedge clk); btn_step = 1'b0;
        @(negedge clk); btn_step = 1'b1;
        ec = cyc + DEB_CYC + 3;
        expect_step(ec);
        repeat (6) @(negedge clk); btn_step = 1'b0;
        repeat (DEB_CYC + 8) @(negedge clk);

        // Channel change after a snapshot must not reach the snapshot display
        ch_data[31:0] = 32'h55555555;
        repeat (4) @(negedge clk);
        press(3'b010, 6, 1'b0, '0);
        ch_data[63:32] = 32'h66666666;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) press(3'b010, 7, 1'b0, '0);

        // All three buttons pressed together
        press(3'b111, 8, 1'b1, 32'hCAFEF00D);

        // Randomised panel activity
        for (int i = 0; i < 30; i++) begin
            b    = 3'($urandom_range(1, 7));
            hold = $urandom_range(DEB_CYC + 1, 12);
            en   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, NCH - 1);
                @(negedge clk);
                ch_data[c*W +: W] = $urandom;
            end
            press(b, hold, en, $urandom);
        end

        // Make sure the display is off blank so the async reset is visible there too
        if (ms == 0) press(3'b010, 6, 1'b0, '0);

        // Reset mid-debounce, buttons held through reset release
        @(negedge clk);
        load_en  = 1'b1;
        sw       = 32'h0BADF00D;
        btn_load = 1'b1;
        btn_clk  = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_reset("async");
        reset_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ec = cyc + DEB_CYC + 3;
        expect_load(ec, 32'h0BADF00D);
        mq.push_back(ec);
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        btn_clk  = 1'b0;
        repeat (DEB_CYC + 10) @(negedge clk);

        chk("load_queue_drained", lq.size(), 0);
        chk("disp_queue_drained", dq.size(), 0);
        chk("clk_queue_drained",  mq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_io_seq.md
# board_io_seq

Clock-synchronous front-panel controller for the lab board top level. It debounces the raw push-buttons, sequences multi-word operand entry from the switch bank into NLOAD parameter slots, and generates single-cycle manual-clock pulses. It also steps the seven-segment display through NCH data channels, a lamp-test (all-8) mode and blank. It replaces button-edge-clocked logic: every flop runs on `clk`, and raw button signals are data inputs only.

## Interface
- W, 32: switch bank / data word width.
- NLOAD, 3: number of parameter slots loaded in sequence.
- NCH, 4: number of display data channels.
- DEB_CYC, 20: consecutive stable cycles required to accept a button level change (≥2).
- LIVE, 0: 0 = display word snapshotted on step; 1 = display tracks the selected channel continuously.
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- sw  in  W  switch bank.
- load_en  in  1  level enable for slot loading.
- btn_load  in  1  raw load button.
- btn_step  in  1  raw display-step button.
- btn_clk  in  1  raw manual-clock button.
- ch_data  in  NCH*W  channel k at [k*W +: W].
- load_word  out  NLOAD*W  captured slots, slot k at [k*W +: W].
- load_valid  out  NLOAD  sticky bit per slot, set when that slot has been written.
- load_idx  out  clog2(NLOAD) (min 1)  next slot to be written.
- load_stb  out  1  one-cycle strobe after any slot capture.
- man_clk  out  1  one-cycle manual clock pulse.
- disp_sel  out  clog2(NCH+2)  display state index.
- disp_data  out  W  word to display.
- disp_all8  out  1  lamp-test request to the display driver.

## Operation
- Per button: 2-flop synchroniser, then a debounce counter against the debounced level `deb`. If the synchronised value equals `deb`, the counter clears. Otherwise the counter increments; on the DEB_CYC-th consecutive mismatch, `deb` takes the new value and the counter clears. Press pulse = `deb` & ~`deb` delayed by one cycle. Releases produce no pulse.
- Load sequencer, on a load pulse:
  - load_en=1: capture `sw` into slot load_idx, set load_valid[load_idx], assert load_stb, then advance load_idx. From NLOAD-1 it wraps to 0; wrap overwrites the slot and keeps the valid bits.
  - load_en=0: pulse ignored; no state change and no strobe.
- Manual clock: man_clk = btn_clk press pulse, registered.
- Display FSM, disp_sel ∈ {0 … NCH+1}; each step pulse advances it by one, and NCH+1 goes to 0.
  - 0 = BLANK: disp_data=0, disp_all8=0.
  - 1..NCH = channel disp_sel−1.
  - NCH+1 = LAMP: disp_all8=1, disp_data holds its previous value.
  - LIVE=0: on the step into a channel state, disp_data latches ch_data for that channel.
  - LIVE=1: disp_data follows ch_data of the selected channel every cycle, registered with 1-cycle lag.
- Load, step and clock paths are independent; simultaneous pulses are all honoured in the same cycle.

## Timing
- Reset values: all slots 0, load_valid=0, load_idx=0, load_stb=0, man_clk=0, disp_sel=0, disp_data=0, disp_all8=0. All debounce levels and counters are 0.
- Raw input rising, first sampled high at edge e0 and held stable: `deb` rises at edge e(DEB_CYC+1), and the press pulse is high for the cycle after it. The pulse's effects (slot capture, load_stb, man_clk, disp_sel update, LIVE=0 snapshot) register at e(DEB_CYC+2); each of load_stb and man_clk is high for exactly one cycle.
- A glitch shorter than DEB_CYC cycles produces no pulse. Bounce restarts the count.
- A button held through reset deassertion produces one pulse DEB_CYC+2 edges after release of rst.
- Reset mid-debounce or mid-sequence aborts immediately (asynchronously) to reset values. Nothing partial persists.
- Holding a button yields exactly one pulse; a new pulse requires a debounced release followed by a new press.

## Test plan
- DEB_CYC=4, NLOAD=3: press btn_load with load_en=1 and sw=0x12345678, held 10 cycles -> exactly one load_stb; slot0=0x12345678; load_valid=3'b001; load_idx=1.
- Three further presses with sw=A,B,C -> slot1=A, slot2=B, then wrap so slot0=C; load_idx=1; load_valid=3'b111. A press with load_en=0 -> no change, load_stb stays 0.
- btn_step bounce (high 2 cycles, low 1, high 6) -> exactly one disp_sel increment, 4+2 edges after the final rising sample.
- NCH=4, LIVE=0, ch_data channels = 0x11…, 0x22…, 0x33…, 0x44…: 6 steps -> disp_sel 1,2,3,4,5,0. disp_data shows the four channel words, then keeps 0x44… with disp_all8=1, then 0 with disp_all8=0. A change to ch_data after a snapshot does not alter disp_data.
- LIVE=1: in disp_sel=2, change ch_data channel 1 -> disp_data follows one cycle later.
- Simultaneous btn_load+btn_step+btn_clk presses -> load_stb, man_clk and the disp_sel step all occur at the same edge. Assert rst mid-debounce -> all outputs return to reset values immediately.
